// File: rtl/keypad_scanner.sv
// 6x4 active-low keypad scanner: row scan, press/release debounce, calculator keycodes.
// Optional auto-repeat for digit keys is compiled in with `define KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    output logic [5:0] row,
    input  logic [3:0] col,
    output logic       new_key,
    output logic [4:0] keycode
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("keypad_scanner: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESS,
        ST_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        row_idx_q, row_idx_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [5:0]        row_q, row_d;
    logic              new_key_q, new_key_d;
    logic [4:0]        keycode_q, keycode_d;
    logic [3:0]        col_meta_q, col_meta_d;
    logic [3:0]        col_sync_q, col_sync_d;
    logic [5:0]        press_info;
    logic [2:0]        next_row;
`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              rep_ok_q, rep_ok_d;
`endif

    // Returns {assigned, keycode} for the key at row r, column c.
    function automatic logic [5:0] key_lookup(input logic [2:0] r, input logic [1:0] c);
        logic [5:0] res;
        res = {1'b1, 1'b1, r[1:0], c};
        if (r == 3'd4) begin
            case (c)
                2'd0:    res = 6'b1_01011;
                2'd1:    res = 6'b1_01010;
                2'd2:    res = 6'b1_01001;
                default: res = 6'b1_00100;
            endcase
        end else if (r == 3'd5) begin
            case (c)
                2'd0:    res = 6'b1_00010;
                2'd1:    res = 6'b1_00001;
                2'd2:    res = 6'b1_01100;
                default: res = 6'b0_00000;
            endcase
        end
        return res;
    endfunction

    function automatic logic [1:0] lowest_low(input logic [3:0] c);
        logic [1:0] idx;
        if (!c[0])      idx = 2'd0;
        else if (!c[1]) idx = 2'd1;
        else if (!c[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        col_idx_d  = col_idx_q;
        div_cnt_d  = div_cnt_q;
        db_cnt_d   = db_cnt_q;
        new_key_d  = 1'b0;
        keycode_d  = keycode_q;
        col_meta_d = col;
        col_sync_d = col_meta_q;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d  = rep_cnt_q;
        rep_ok_d   = rep_ok_q;
`endif
        press_info = key_lookup(row_idx_q, col_idx_q);
        next_row   = (row_idx_q == 3'd5) ? 3'd0 : row_idx_q + 3'd1;

        case (state_q)
            ST_SCAN: begin
                if (div_cnt_q == DIV_W'(SCAN_DIV - 1)) begin
                    div_cnt_d = '0;
                    if (col_sync_q != 4'hf) begin
                        col_idx_d = lowest_low(col_sync_q);
                        db_cnt_d  = '0;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        row_idx_d = next_row;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!col_sync_q[col_idx_q]) begin
                    if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        db_cnt_d = '0;
                        state_d  = ST_PRESS;
                        // Pulse is registered so it is high exactly while in PRESS.
                        if (press_info[5]) begin
                            new_key_d = 1'b1;
                            keycode_d = press_info[4:0];
                        end
`ifdef KEYPAD_REPEAT_EN
                        rep_ok_d = press_info[5] & press_info[4];
`endif
                    end else begin
                        db_cnt_d = db_cnt_q + DB_W'(1);
                    end
                end else begin
                    db_cnt_d  = '0;
                    div_cnt_d = '0;
                    row_idx_d = next_row;
                    state_d   = ST_SCAN;
                end
            end
            ST_PRESS: begin
                db_cnt_d = '0;
                state_d  = ST_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt_d = REP_W'(1);
`endif
            end
            default: begin
                if (col_sync_q == 4'hf) begin
                    if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        db_cnt_d  = '0;
                        div_cnt_d = '0;
                        row_idx_d = 3'd0;
                        state_d   = ST_SCAN;
                    end else begin
                        db_cnt_d = db_cnt_q + DB_W'(1);
                    end
                end else begin
                    db_cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                    // Repeat timer runs only while held and is independent of the release counter.
                    if (rep_ok_q) begin
                        if (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1)) begin
                            new_key_d = 1'b1;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_W'(1);
                        end
                    end
`endif
                end
            end
        endcase

        row_d = ~(6'b000001 << row_idx_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_SCAN;
            row_idx_q  <= 3'd0;
            col_idx_q  <= 2'd0;
            div_cnt_q  <= '0;
            db_cnt_q   <= '0;
            row_q      <= 6'b111110;
            new_key_q  <= 1'b0;
            keycode_q  <= 5'b00000;
            col_meta_q <= 4'h0;
            col_sync_q <= 4'h0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q  <= '0;
            rep_ok_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            col_idx_q  <= col_idx_d;
            div_cnt_q  <= div_cnt_d;
            db_cnt_q   <= db_cnt_d;
            row_q      <= row_d;
            new_key_q  <= new_key_d;
            keycode_q  <= keycode_d;
            col_meta_q <= col_meta_d;
            col_sync_q <= col_sync_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q  <= rep_cnt_d;
            rep_ok_q   <= rep_ok_d;
`endif
        end
    end

    assign row     = row_q;
    assign new_key = new_key_q;
    assign keycode = keycode_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 6x4 key matrix.
// Define KEYPAD_REPEAT_EN for both bench and RTL to exercise auto-repeat.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 8;
    localparam int REP      = 32;
    localparam int MAX_LAT  = 6 * SCAN_DIV + DB + 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  row;
    logic [3:0]  col;
    logic        new_key;
    logic [4:0]  keycode;
    logic [23:0] keys = '0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int row_bad     = 0;
    int double_hits = 0;
    logic prev_new_key = 1'b0;

    logic [4:0] exp_q[$];
    logic [4:0] pulse_code_q[$];
    int         pulse_cyc_q[$];

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .row(row),
        .col(col),
        .new_key(new_key),
        .keycode(keycode)
    );

    // Clock and cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Key matrix: a pressed key shorts its column to the driven (low) row.
    always_comb begin
        col = 4'hf;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 4; c++)
                if (!row[r] && keys[4*r+c]) col[c] = 1'b0;
    end

    // Pulse recorder and structural observers, sampled on the falling edge.
    always @(negedge clock) begin
        if (new_key) begin
            pulse_code_q.push_back(keycode);
            pulse_cyc_q.push_back(cyc);
            if (prev_new_key) double_hits++;
        end
        prev_new_key = new_key;
        if ($countones(~row) != 1) row_bad++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_row_entry(input logic [5:0] target, output bit ok);
        logic [5:0] prev;
        ok   = 1'b0;
        prev = row;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (row == target && prev != target) ok = 1'b1;
            prev = row;
        end
    endtask

    task automatic wait_pulse(input int count_target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (pulse_code_q.size() >= count_target) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        keys  = '0;
        tick(3);
        vectors += 3;
        if (row !== 6'b111110) begin miscompares++; $display("FAIL reset_row: got %b expected %b", row, 6'b111110); end
        if (new_key !== 1'b0) begin miscompares++; $display("FAIL reset_new_key: got %b expected 0", new_key); end
        if (keycode !== 5'b00000) begin miscompares++; $display("FAIL reset_keycode: got %b expected 00000", keycode); end
        reset = 1'b1;
        tick(3);
        vectors++;
        if (row !== 6'b111110) begin miscompares++; $display("FAIL scan_row0_hold: got %b expected %b", row, 6'b111110); end
        tick(1);
        vectors++;
        if (row !== 6'b111101) begin miscompares++; $display("FAIL scan_row1_step: got %b expected %b", row, 6'b111101); end
    endtask

    task automatic test_single_key;
        int base;
        int start;
        bit ok;
        base  = pulse_code_q.size();
        exp_q.push_back(5'b11001);
        keys[9] = 1'b1;
        start = cyc;
        wait_pulse(base + 1, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL single_pulse_timeout: got no pulse expected one");
        end else begin
            vectors += 2;
            if (pulse_cyc_q[base] - start > MAX_LAT) begin
                miscompares++; $display("FAIL single_latency: got %0d expected <= %0d", pulse_cyc_q[base] - start, MAX_LAT);
            end
            if (pulse_code_q[base] !== 5'b11001) begin
                miscompares++; $display("FAIL single_code: got %b expected 11001", pulse_code_q[base]);
            end
        end
        tick(60);
        keys[9] = 1'b0;
        tick(40);
        vectors += 2;
        if (pulse_code_q.size() - base != 1) begin
            miscompares++; $display("FAIL single_count: got %0d expected 1", pulse_code_q.size() - base);
        end
        if (keycode !== 5'b11001) begin miscompares++; $display("FAIL single_keycode_hold: got %b expected 11001", keycode); end
    endtask

    task automatic test_glitch;
        int base;
        bit ok;
        base = pulse_code_q.size();
        wait_row_entry(6'b101111, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL glitch_row4_timeout: got no row4 expected row4"); end
        keys[16] = 1'b1;
        tick(3);
        keys[16] = 1'b0;
        tick(20);
        vectors++;
        if (pulse_code_q.size() != base) begin
            miscompares++; $display("FAIL glitch_no_pulse: got %0d pulses expected 0", pulse_code_q.size() - base);
        end
        exp_q.push_back(5'b01011);
        keys[16] = 1'b1;
        wait_pulse(base + 1, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL glitch_stable_timeout: got no pulse expected one");
        end else if (keycode !== 5'b01011) begin
            miscompares++; $display("FAIL glitch_code: got %b expected 01011", keycode);
        end
        tick(20);
        keys[16] = 1'b0;
        tick(40);
        vectors++;
        if (pulse_code_q.size() - base != 1) begin
            miscompares++; $display("FAIL glitch_count: got %0d expected 1", pulse_code_q.size() - base);
        end
    endtask

    task automatic test_two_keys;
        int base;
        bit ok;
        base = pulse_code_q.size();
        exp_q.push_back(5'b10100);
        keys[4] = 1'b1;
        keys[6] = 1'b1;
        wait_pulse(base + 1, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL two_keys_timeout: got no pulse expected one");
        end else if (keycode !== 5'b10100) begin
            miscompares++; $display("FAIL two_keys_code: got %b expected 10100", keycode);
        end
        keys[4] = 1'b0;
        tick(40);
        vectors += 2;
        if (pulse_code_q.size() - base != 1) begin
            miscompares++; $display("FAIL two_keys_partial_release: got %0d pulses expected 1", pulse_code_q.size() - base);
        end
        if (row !== 6'b111101) begin miscompares++; $display("FAIL two_keys_row_hold: got %b expected 111101", row); end
        keys[6] = 1'b0;
        tick(40);
        vectors++;
        if (pulse_code_q.size() - base != 1) begin
            miscompares++; $display("FAIL two_keys_count: got %0d expected 1", pulse_code_q.size() - base);
        end
    endtask

    task automatic test_unassigned;
        int base;
        base = pulse_code_q.size();
        keys[23] = 1'b1;
        tick(100);
        vectors += 3;
        if (pulse_code_q.size() != base) begin
            miscompares++; $display("FAIL unassigned_no_pulse: got %0d pulses expected 0", pulse_code_q.size() - base);
        end
        if (keycode !== 5'b10100) begin miscompares++; $display("FAIL unassigned_keycode: got %b expected 10100", keycode); end
        if (row !== 6'b011111) begin miscompares++; $display("FAIL unassigned_row_hold: got %b expected 011111", row); end
        keys[23] = 1'b0;
        tick(9);
        vectors++;
        if (row !== 6'b011111) begin miscompares++; $display("FAIL release_not_early: got %b expected 011111", row); end
        tick(3);
        vectors++;
        if (row !== 6'b111110) begin miscompares++; $display("FAIL release_to_row0: got %b expected 111110", row); end
    endtask

    task automatic test_reset_mid_debounce;
        int base;
        bit ok;
        base = pulse_code_q.size();
        wait_row_entry(6'b111110, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL midreset_row0_timeout: got no row0 expected row0"); end
        keys[0] = 1'b1;
        tick(7);
        vectors++;
        if (pulse_code_q.size() != base) begin
            miscompares++; $display("FAIL midreset_early_pulse: got %0d pulses expected 0", pulse_code_q.size() - base);
        end
        reset   = 1'b0;
        keys[0] = 1'b0;
        #1;
        vectors += 3;
        if (row !== 6'b111110) begin miscompares++; $display("FAIL midreset_row: got %b expected 111110", row); end
        if (new_key !== 1'b0) begin miscompares++; $display("FAIL midreset_new_key: got %b expected 0", new_key); end
        if (keycode !== 5'b00000) begin miscompares++; $display("FAIL midreset_keycode: got %b expected 00000", keycode); end
        tick(3);
        reset = 1'b1;
        tick(60);
        vectors += 2;
        if (pulse_code_q.size() != base) begin
            miscompares++; $display("FAIL midreset_no_pulse: got %0d pulses expected 0", pulse_code_q.size() - base);
        end
        if (keycode !== 5'b00000) begin miscompares++; $display("FAIL midreset_keycode_after: got %b expected 00000", keycode); end
    endtask

    task automatic test_hold_repeat;
        int base;
        int exp_n;
        int t0;
        bit ok;
        base = pulse_code_q.size();
`ifdef KEYPAD_REPEAT_EN
        exp_n = 4;
`else
        exp_n = 1;
`endif
        for (int i = 0; i < exp_n; i++) exp_q.push_back(5'b10011);
        keys[3] = 1'b1;
        wait_pulse(base + 1, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL hold_digit_timeout: got no pulse expected one"); end
        t0 = ok ? pulse_cyc_q[base] : cyc;
        tick(99);
        keys[3] = 1'b0;
        tick(40);
        vectors += 2;
        if (pulse_code_q.size() - base != exp_n) begin
            miscompares++; $display("FAIL hold_digit_count: got %0d expected %0d", pulse_code_q.size() - base, exp_n);
        end
        if (keycode !== 5'b10011) begin miscompares++; $display("FAIL hold_digit_keycode: got %b expected 10011", keycode); end
`ifdef KEYPAD_REPEAT_EN
        if (pulse_code_q.size() - base == exp_n) begin
            vectors += 2;
            if (pulse_cyc_q[base+1] - t0 != REP) begin
                miscompares++; $display("FAIL repeat_first_gap: got %0d expected %0d", pulse_cyc_q[base+1] - t0, REP);
            end
            if (pulse_cyc_q[base+3] - t0 != 3 * REP) begin
                miscompares++; $display("FAIL repeat_third_gap: got %0d expected %0d", pulse_cyc_q[base+3] - t0, 3 * REP);
            end
        end
`endif
        base = pulse_code_q.size();
        exp_q.push_back(5'b00100);
        keys[19] = 1'b1;
        wait_pulse(base + 1, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL hold_equals_timeout: got no pulse expected one"); end
        tick(100);
        keys[19] = 1'b0;
        tick(40);
        vectors += 2;
        if (pulse_code_q.size() - base != 1) begin
            miscompares++; $display("FAIL hold_equals_count: got %0d expected 1", pulse_code_q.size() - base);
        end
        if (keycode !== 5'b00100) begin miscompares++; $display("FAIL hold_equals_keycode: got %b expected 00100", keycode); end
    endtask

    initial begin
        test_reset;
        test_single_key;
        test_glitch;
        test_two_keys;
        test_unassigned;
        test_reset_mid_debounce;
        test_hold_repeat;

        // Final report: every recorded pulse against the expected queue.
        vectors++;
        if (pulse_code_q.size() != exp_q.size()) begin
            miscompares++; $display("FAIL scoreboard_count: got %0d pulses expected %0d", pulse_code_q.size(), exp_q.size());
        end
        for (int i = 0; i < pulse_code_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (pulse_code_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL scoreboard_code_%0d: got %b expected %b", i, pulse_code_q[i], exp_q[i]);
            end
        end
        vectors += 2;
        if (row_bad != 0) begin miscompares++; $display("FAIL row_one_hot: got %0d bad samples expected 0", row_bad); end
        if (double_hits != 0) begin miscompares++; $display("FAIL new_key_back_to_back: got %0d expected 0", double_hits); end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clocks each row is driven during scanning; legal minimum 4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 20000: consecutive stable clocks required to accept a press or a release.
REQ-003 Parameter REPEAT_CYCLES, default 5000000: auto-repeat period; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 Port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port row  output  6  keypad row drive, active-low; exactly one bit low at all times.
REQ-007 Port col  input  4  keypad column sense, active-low; asynchronous to clock.
REQ-008 Port new_key  output  1  one-clock pulse per accepted key event.
REQ-009 Port keycode  output  5  code of the most recently accepted key, using the calculator keycode set.

Function
REQ-010 col SHALL pass through a 2-flop synchroniser; only synchronised values are used internally.
REQ-011 Key index SHALL be k = 4*r + c for row r in 0..5 and column c in 0..3.
REQ-012 Keys k = 0..15 SHALL map to keycode {1, k[3:0]}.
REQ-013 Row 4 SHALL map c0..c3 to add 01011, sub 01010, mul 01001 and equals 00100.
REQ-014 Row 5 SHALL map c0..c2 to clear 00010, store 00001 and recall 01100; r5c3 is unassigned.
REQ-015 FSM states SHALL be SCAN, DEBOUNCE, PRESS and RELEASE.
REQ-016 SCAN: drive row r for SCAN_DIV clocks, sample synchronised col on the last clock, then advance r to (r+1) mod 6.
REQ-017 SCAN transition: if any sampled column is low, capture r and the lowest-index low column, hold the row, and go to DEBOUNCE.
REQ-018 DEBOUNCE: count consecutive clocks on which the captured column stays low.
REQ-019 DEBOUNCE, on a mismatch: clear the counter and return to SCAN at row (r+1) mod 6 with no output change.
REQ-020 DEBOUNCE, when the count reaches DEBOUNCE_CYCLES: go to PRESS.
REQ-021 PRESS SHALL last exactly 1 clock.
REQ-022 PRESS, assigned key: new_key=1 and keycode updated on the same clock.
REQ-023 PRESS, unassigned key: no pulse and keycode unchanged.
REQ-024 PRESS SHALL always be followed by RELEASE.
REQ-025 RELEASE: hold the row; when all four synchronised columns have been high for DEBOUNCE_CYCLES consecutive clocks, go to SCAN at row 0.
REQ-026 RELEASE: any low column clears the release counter.
REQ-027 Simultaneous presses: only the first key found in scan order is reported; others are ignored until full release.
REQ-028 keycode SHALL hold its value between pulses.
REQ-029 new_key SHALL never be high on two consecutive clocks.
REQ-030 Press-to-pulse latency SHALL be at most 6*SCAN_DIV + DEBOUNCE_CYCLES + 4 clocks.
REQ-031 Counters SHALL be sized for the parameters so that no wrap-around occurs.

Reset
REQ-032 Reset assertion SHALL immediately force: state SCAN, r=0, row=6'b111110, all counters and synchroniser flops 0, new_key=0, keycode=5'b00000.
REQ-033 Reset mid-debounce or mid-release SHALL abandon the event with no pulse.
REQ-034 After reset release, scanning SHALL begin at row 0.

Configuration
REQ-035 With KEYPAD_REPEAT_EN defined, and only for digit keys (keycode[4]=1), RELEASE SHALL re-pulse new_key with the same keycode every REPEAT_CYCLES clocks of continuous hold.
REQ-036 A release-counter restart caused by any low column SHALL NOT reset the repeat timer.
REQ-037 Without KEYPAD_REPEAT_EN, exactly one pulse per press SHALL be produced, and the repeat logic and REPEAT_CYCLES counter SHALL be absent.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32)
REQ-038 Hold r2c1 (k=9) stable -> exactly one new_key pulse with keycode 11001; keycode stays 11001 after release.
REQ-039 r4c0 low with a 3-clock glitch, then stable -> no pulse for the glitch; one pulse with keycode 01011 after 8 stable clocks.
REQ-040 r1c0 and r1c2 low together -> single pulse with keycode 10100; no second pulse until both are released for 8 clocks.
REQ-041 Press r5c3 -> no pulse and keycode unchanged; scanner returns to SCAN at row 0 after release.
REQ-042 Assert reset during DEBOUNCE of r0c0 -> row=111110, new_key=0, keycode=00000 immediately; no pulse afterwards while the key stays released.
REQ-043 KEYPAD_REPEAT_EN defined, hold r0c3 for 100 clocks after acceptance -> pulses with keycode 10011 at acceptance and every 32 clocks thereafter; holding r4c3 -> exactly one pulse with 00100.
